// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Accepted operations return through a single registered response slot.
module alu_arbiter #(
  parameter int DWIDTH = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req0_Valid,
  output logic              Req0_Ready,
  input  logic [DWIDTH-1:0] Req0_A,
  input  logic [DWIDTH-1:0] Req0_B,
  input  logic [3:0]        Req0_OP,
  input  logic              Req1_Valid,
  output logic              Req1_Ready,
  input  logic [DWIDTH-1:0] Req1_A,
  input  logic [DWIDTH-1:0] Req1_B,
  input  logic [3:0]        Req1_OP,
  output logic [DWIDTH-1:0] ALU_In_A,
  output logic [DWIDTH-1:0] ALU_In_B,
  output logic [3:0]        ALU_OP,
  input  logic [DWIDTH-1:0] ALU_Out,
  input  logic              ALU_Zero_Flag,
  output logic              Rsp_Valid,
  input  logic              Rsp_Ready,
  output logic              Rsp_Id,
  output logic [DWIDTH-1:0] Rsp_Data,
  output logic              Rsp_Zero,
  output logic              Rsp_Err
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic              zero_q, zero_d;
  logic              id_q, id_d;
  logic              err_q, err_d;

  logic gnt0, gnt1, slot_free, accept;

  function automatic logic op_is_err(input logic [3:0] op);
    return op > 4'd9;
  endfunction

  always_comb begin
    // On a tie the requester that did not win the last acceptance goes first.
    gnt0       = Req0_Valid & (~Req1_Valid | last_q);
    gnt1       = Req1_Valid & (~Req0_Valid | ~last_q);
    slot_free  = (state_q == EMPTY) | Rsp_Ready;
    Req0_Ready = gnt0 & slot_free & ~Reset;
    Req1_Ready = gnt1 & slot_free & ~Reset;
    accept     = Req0_Ready | Req1_Ready;
  end

  always_comb begin
    ALU_In_A = '0;
    ALU_In_B = '0;
    ALU_OP   = '0;
    if (gnt0) begin
      ALU_In_A = Req0_A;
      ALU_In_B = Req0_B;
      ALU_OP   = Req0_OP;
    end else if (gnt1) begin
      ALU_In_A = Req1_A;
      ALU_In_B = Req1_B;
      ALU_OP   = Req1_OP;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    data_d  = data_q;
    zero_d  = zero_q;
    id_d    = id_q;
    err_d   = err_q;
    if (accept) begin
      state_d = FULL;
      last_d  = Req1_Ready;
      data_d  = ALU_Out;
      zero_d  = ALU_Zero_Flag;
      id_d    = Req1_Ready;
      err_d   = op_is_err(ALU_OP);
    end else if (state_q == FULL && Rsp_Ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= EMPTY;
      last_q  <= 1'b1;
      data_q  <= '0;
      zero_q  <= 1'b0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
      id_q    <= id_d;
      err_q   <= err_d;
    end
  end

  assign Rsp_Valid = (state_q == FULL);
  assign Rsp_Id    = id_q;
  assign Rsp_Data  = data_q;
  assign Rsp_Zero  = zero_q;
  assign Rsp_Err   = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU plus a transaction-level model of
// the single response slot, driven by directed steps and a random run.
module tb_alu_arbiter;
  localparam int DW = 32;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          v0, v1, r0, r1, rsp_rdy;
  logic [DW-1:0] a0, b0, a1, b1;
  logic [3:0]    op0, op1;
  logic [DW-1:0] alu_a, alu_b, alu_out;
  logic [3:0]    alu_op;
  logic          alu_zero;
  logic          rsp_valid, rsp_id, rsp_zero, rsp_err;
  logic [DW-1:0] rsp_data;

  always #5 Clk = ~Clk;

  alu_arbiter #(.DWIDTH(DW)) dut (
    .Clk(Clk), .Reset(Reset),
    .Req0_Valid(v0), .Req0_Ready(r0), .Req0_A(a0), .Req0_B(b0), .Req0_OP(op0),
    .Req1_Valid(v1), .Req1_Ready(r1), .Req1_A(a1), .Req1_B(b1), .Req1_OP(op1),
    .ALU_In_A(alu_a), .ALU_In_B(alu_b), .ALU_OP(alu_op),
    .ALU_Out(alu_out), .ALU_Zero_Flag(alu_zero),
    .Rsp_Valid(rsp_valid), .Rsp_Ready(rsp_rdy), .Rsp_Id(rsp_id),
    .Rsp_Data(rsp_data), .Rsp_Zero(rsp_zero), .Rsp_Err(rsp_err)
  );

  function automatic logic [DW-1:0] ref_alu(input logic [3:0] op,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a << b[4:0];
      4'd3: return a >> b[4:0];
      4'd4: return $signed(a) >>> b[4:0];
      4'd5: return a ^ b;
      4'd6: return a | b;
      4'd7: return {{(DW-1){1'b0}}, $signed(a) < $signed(b)};
      4'd8: return {{(DW-1){1'b0}}, a < b};
      4'd9: return a & b;
      default: return '0;
    endcase
  endfunction

  always_comb begin
    alu_out  = ref_alu(alu_op, alu_a, alu_b);
    alu_zero = (alu_out == '0);
  end

  int total = 0;
  int bad   = 0;

  // Model: the response slot holds at most one result.
  bit            m_full = 0;
  bit            m_show = 0;
  bit            m_last = 1;
  logic [DW-1:0] m_data = '0;
  bit            m_zero = 0, m_id = 0, m_err = 0;
  int            acc_obs = 0, del_obs = 0, wait0 = 0, wait1 = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are already set; checks combinational outputs, crosses the edge,
  // then checks the registered response at the following falling edge.
  task automatic cycle();
    int g;
    bit acc;
    #1;
    g = -1;
    if (v0 && v1)  g = m_last ? 0 : 1;
    else if (v0)   g = 0;
    else if (v1)   g = 1;
    acc = !Reset && (g >= 0) && (!m_full || rsp_rdy);
    chk("req0_ready", r0, acc && g == 0);
    chk("req1_ready", r1, acc && g == 1);
    if (!Reset) begin
      if (g == 0) begin
        chk("alu_a0", alu_a, a0); chk("alu_b0", alu_b, b0); chk("alu_op0", alu_op, op0);
      end else if (g == 1) begin
        chk("alu_a1", alu_a, a1); chk("alu_b1", alu_b, b1); chk("alu_op1", alu_op, op1);
      end else begin
        chk("alu_a_idle", alu_a, 0); chk("alu_b_idle", alu_b, 0); chk("alu_op_idle", alu_op, 0);
      end
      if (rsp_valid && rsp_rdy) del_obs++;
      if (r0 || r1) begin
        acc_obs++;
        if (r0) begin wait0 = 0; wait1 = v1 ? wait1 + 1 : 0; end
        else    begin wait1 = 0; wait0 = v0 ? wait0 + 1 : 0; end
        chk("starve0", wait0 <= 1, 1);
        chk("starve1", wait1 <= 1, 1);
      end
      if (!v0) wait0 = 0;
      if (!v1) wait1 = 0;
    end
    @(posedge Clk);
    if (Reset) begin
      m_full = 0; m_show = 1; m_last = 1;
      m_data = '0; m_zero = 0; m_id = 0; m_err = 0;
      wait0 = 0; wait1 = 0;
    end else if (acc) begin
      m_full = 1; m_show = 1; m_last = (g == 1); m_id = (g == 1);
      m_data = (g == 1) ? ref_alu(op1, a1, b1) : ref_alu(op0, a0, b0);
      m_zero = (m_data == '0);
      m_err  = ((g == 1) ? op1 : op0) >= 4'd10;
    end else if (m_full && rsp_rdy) begin
      m_full = 0; m_show = 0;
    end
    @(negedge Clk);
    chk("rsp_valid", rsp_valid, m_full);
    if (m_show) begin
      chk("rsp_data", rsp_data, m_data);
      chk("rsp_zero", rsp_zero, m_zero);
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_err", rsp_err, m_err);
    end
  endtask

  task automatic set_req(input logic vv0, input logic [3:0] o0, input logic [DW-1:0] x0, input logic [DW-1:0] y0,
                         input logic vv1, input logic [3:0] o1, input logic [DW-1:0] x1, input logic [DW-1:0] y1);
    v0 = vv0; op0 = o0; a0 = x0; b0 = y0;
    v1 = vv1; op1 = o1; a1 = x1; b1 = y1;
  endtask

  initial begin
    int cyc;
    int seed;
    seed = $urandom(32'd1234);
    Reset = 1; rsp_rdy = 0;
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(); cycle();
    chk("reset_valid", rsp_valid, 0);
    chk("reset_data", rsp_data, 0);

    // Single requester, subtract, response one cycle later.
    Reset = 0; rsp_rdy = 1;
    set_req(1, 4'b0001, 5, 3, 0, 0, 0, 0);
    cycle();
    chk("t34_valid", rsp_valid, 1);
    chk("t34_data", rsp_data, 2);
    chk("t34_id", rsp_id, 0);
    chk("t34_zero", rsp_zero, 0);

    // Continuous tie alternates starting with requester 0.
    Reset = 1; set_req(0, 0, 0, 0, 0, 0, 0, 0); cycle();
    Reset = 0;
    set_req(1, 4'b0000, 1, 1, 1, 4'b0101, 7, 7);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t35_id", rsp_id, i % 2);
      chk("t35_data", rsp_data, (i % 2) ? 0 : 2);
      chk("t35_zero", rsp_zero, i % 2);
    end

    // Stall the held result for four cycles, then release.
    rsp_rdy = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t36_valid", rsp_valid, 1);
    end
    rsp_rdy = 1;
    cycle();

    // Unimplemented opcode from requester 1.
    set_req(0, 0, 0, 0, 1, 4'b1100, 32'hFFFF_FFFF, 1);
    cycle();
    chk("t37_err", rsp_err, 1);
    chk("t37_data", rsp_data, 0);
    chk("t37_zero", rsp_zero, 1);
    chk("t37_id", rsp_id, 1);

    // Reset while holding a stalled result.
    rsp_rdy = 0;
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    Reset = 1;
    cycle();
    chk("t38_valid", rsp_valid, 0);
    chk("t38_err", rsp_err, 0);
    chk("t38_id", rsp_id, 0);
    Reset = 0; rsp_rdy = 1;
    set_req(1, 4'd9, 32'hF0F0, 32'hFF00, 1, 4'd6, 1, 2);
    cycle();
    chk("t38_tie_id", rsp_id, 0);
    chk("t38_tie_data", rsp_data, 32'hF000);

    // Random run.
    acc_obs = 0; del_obs = 0; wait0 = 0; wait1 = 0;
    if (m_full) del_obs = -1;
    cyc = 0;
    while (acc_obs < 1000 && cyc < 20000) begin
      v0 = ($urandom_range(0, 3) != 0);
      v1 = ($urandom_range(0, 3) != 0);
      op0 = 4'($urandom_range(0, 15)); op1 = 4'($urandom_range(0, 15));
      a0 = $urandom; b0 = ($urandom_range(0, 7) == 0) ? a0 : $urandom;
      a1 = $urandom; b1 = ($urandom_range(0, 7) == 0) ? a1 : $urandom;
      rsp_rdy = ($urandom_range(0, 2) != 0);
      cycle();
      cyc++;
    end
    chk("random_budget", acc_obs >= 1000, 1);
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
    rsp_rdy = 1;
    cycle(); cycle();
    chk("returned_once", del_obs, acc_obs);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
